// File: rtl/chip_mmc3x.sv
// MMC3-class mapper: bank registers, PRG/CHR bank mapping, bus decode and the
// scanline IRQ counter, with an optional RAMBO-style extended mode.
module chip_mmc3x #(
  parameter int PRG_W    = 6,
  parameter int CHR_W    = 8,
  parameter int A12_FILT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       cpu_data,
  input  logic             cpu_a14,
  input  logic             cpu_a13,
  input  logic             cpu_a0,
  input  logic             cpu_ce_n,
  input  logic             cpu_rw,
  input  logic             cpu_m2,
  input  logic [2:0]       ppu_addr,
  input  logic             ext_mode,
  input  logic             mir_h,
  output logic             irq_n,
  output logic             ciram_a10,
  output logic             prg_ce_n,
  output logic             ram_ce_n,
  output logic             ram_we_n,
  output logic [PRG_W-1:0] prg_addr,
  output logic [CHR_W-1:0] chr_addr
);

  localparam int FW = $clog2(A12_FILT + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(A12_FILT);

  function automatic logic [7:0] bank_rst(input int i);
    case (i)
      1:       bank_rst = 8'd2;
      2:       bank_rst = 8'd4;
      3:       bank_rst = 8'd5;
      4:       bank_rst = 8'd6;
      5:       bank_rst = 8'd7;
      7:       bank_rst = 8'd1;
      default: bank_rst = 8'd0;
    endcase
  endfunction

  logic [1:0]    m2_s, a12_s;
  logic          m2_d, a12_d;
  logic          m2_fall, wr, a12_evt, presc_evt, clk_evt;
  logic [2:0]    ridx;
  logic [3:0]    sel_idx, bidx, one_k_idx;
  logic          chr_1k, prg_mode, chr_inv, mir;
  logic [1:0]    ram_ctl;
  logic [7:0]    bank_r [16];
  logic [7:0]    irq_latch, irq_cnt, latch_nx, cnt_nx;
  logic          reload, irq_en, pend, irq_mode;
  logic          reload_nx, en_nx, pend_nx, mode_nx;
  logic [1:0]    presc, presc_nx;
  logic [FW-1:0] filt, filt_nx;
  logic [PRG_W-1:0] second_last;
  logic [7:0]    chr_bank;

  // Synchronise M2 and A12, keep one extra flop each for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_s  <= '0;
      a12_s <= '0;
      m2_d  <= 1'b0;
      a12_d <= 1'b0;
    end else begin
      m2_s  <= {m2_s[0], cpu_m2};
      a12_s <= {a12_s[0], ppu_addr[2]};
      m2_d  <= m2_s[1];
      a12_d <= a12_s[1];
    end
  end

  assign m2_fall = m2_d & ~m2_s[1];
  assign wr      = m2_fall & ~cpu_rw & ~cpu_ce_n;
  assign ridx    = {cpu_a14, cpu_a13, cpu_a0};
  assign bidx    = ext_mode ? sel_idx : {1'b0, sel_idx[2:0]};

  // Bank select, bank data, mirroring and RAM control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_idx  <= '0;
      chr_1k   <= 1'b0;
      prg_mode <= 1'b0;
      chr_inv  <= 1'b0;
      mir      <= mir_h;
      ram_ctl  <= '0;
      for (int i = 0; i < 16; i++) bank_r[i] <= bank_rst(i);
    end else if (wr) begin
      case (ridx)
        3'd0: begin
          sel_idx  <= cpu_data[3:0];
          chr_1k   <= cpu_data[5];
          prg_mode <= cpu_data[6];
          chr_inv  <= cpu_data[7];
        end
        3'd1:    bank_r[bidx] <= cpu_data;
        3'd2:    mir <= cpu_data[0];
        3'd3:    ram_ctl <= cpu_data[7:6];
        default: ;
      endcase
    end
  end

  // A12 rise qualifies only after enough M2 falls with A12 held low
  always_comb begin
    filt_nx = filt;
    if (a12_s[1])
      filt_nx = '0;
    else if (m2_fall && filt != FILT_MAX)
      filt_nx = filt + FW'(1);
  end

  assign a12_evt = a12_s[1] & ~a12_d & (filt == FILT_MAX);

  // Register writes are folded in first so a same-cycle event sees them
  always_comb begin
    latch_nx  = irq_latch;
    reload_nx = reload;
    en_nx     = irq_en;
    pend_nx   = pend;
    mode_nx   = irq_mode;
    cnt_nx    = irq_cnt;
    presc_nx  = presc;
    presc_evt = 1'b0;
    if (wr) begin
      case (ridx)
        3'd4: latch_nx = cpu_data;
        3'd5: begin
          reload_nx = 1'b1;
          mode_nx   = cpu_data[0];
        end
        3'd6: begin
          en_nx   = 1'b0;
          pend_nx = 1'b0;
        end
        3'd7:    en_nx = 1'b1;
        default: ;
      endcase
    end
    if (wr && ridx == 3'd5) begin
      presc_nx = '0;
    end else if (m2_fall) begin
      presc_nx  = presc + 2'd1;
      presc_evt = (presc == 2'd3);
    end
    clk_evt = (ext_mode & mode_nx) ? presc_evt : a12_evt;
    if (clk_evt) begin
      if (irq_cnt == 8'd0 || reload_nx) begin
        cnt_nx    = latch_nx;
        reload_nx = 1'b0;
      end else begin
        cnt_nx = irq_cnt - 8'd1;
      end
      if (cnt_nx == 8'd0 && en_nx) pend_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_latch <= '0;
      irq_cnt   <= '0;
      reload    <= 1'b0;
      irq_en    <= 1'b0;
      pend      <= 1'b0;
      irq_mode  <= 1'b0;
      presc     <= '0;
      filt      <= '0;
    end else begin
      irq_latch <= latch_nx;
      irq_cnt   <= cnt_nx;
      reload    <= reload_nx;
      irq_en    <= en_nx;
      pend      <= pend_nx;
      irq_mode  <= mode_nx;
      presc     <= presc_nx;
      filt      <= filt_nx;
    end
  end

  assign irq_n     = ~pend;
  assign ciram_a10 = mir ? ppu_addr[1] : ppu_addr[0];
  assign prg_ce_n  = ~(~cpu_ce_n & cpu_rw);
  assign ram_ce_n  = ~(cpu_ce_n & cpu_a14 & cpu_a13 & ram_ctl[1]);
  assign ram_we_n  = ~(~cpu_rw & ~ram_ctl[0]);

  always_comb begin
    second_last = ext_mode ? bank_r[15][PRG_W-1:0] : {{(PRG_W-1){1'b1}}, 1'b0};
    case ({cpu_a14, cpu_a13})
      2'b00:   prg_addr = prg_mode ? second_last : bank_r[6][PRG_W-1:0];
      2'b01:   prg_addr = bank_r[7][PRG_W-1:0];
      2'b10:   prg_addr = prg_mode ? bank_r[6][PRG_W-1:0] : second_last;
      default: prg_addr = '1;
    endcase
  end

  // chr_inv swaps which A12 half holds the 2K banks
  assign one_k_idx = 4'd2 + {2'b00, ppu_addr[1:0]};

  always_comb begin
    if (ppu_addr[2] ^ chr_inv) begin
      chr_bank = bank_r[one_k_idx];
    end else if (ext_mode && chr_1k) begin
      case (ppu_addr[1:0])
        2'b00:   chr_bank = bank_r[0];
        2'b01:   chr_bank = bank_r[8];
        2'b10:   chr_bank = bank_r[1];
        default: chr_bank = bank_r[9];
      endcase
    end else begin
      chr_bank = {bank_r[{3'b000, ppu_addr[1]}][7:1], ppu_addr[0]};
    end
    chr_addr = chr_bank[CHR_W-1:0];
  end

endmodule

// File: tb/tb_chip_mmc3x.sv
// Scoreboard bench for chip_mmc3x: expectations are queued as stimulus is
// applied and compared against the DUT outputs once they have settled.
module tb_chip_mmc3x;

  localparam int PRG_W = 6;
  localparam int CHR_W = 8;

  localparam int K_PRG = 0, K_CHR = 1, K_IRQ = 2, K_CIRAM = 3;
  localparam int K_RAMCE = 4, K_RAMWE = 5, K_PRGCE = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       cpu_data;
  logic             cpu_a14, cpu_a13, cpu_a0;
  logic             cpu_ce_n, cpu_rw, cpu_m2;
  logic [2:0]       ppu_addr;
  logic             ext_mode, mir_h;
  logic             irq_n, ciram_a10, prg_ce_n, ram_ce_n, ram_we_n;
  logic [PRG_W-1:0] prg_addr;
  logic [CHR_W-1:0] chr_addr;

  typedef struct {
    string       tag;
    int          kind;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  chip_mmc3x #(.PRG_W(PRG_W), .CHR_W(CHR_W), .A12_FILT(3)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_data(cpu_data),
    .cpu_a14(cpu_a14), .cpu_a13(cpu_a13), .cpu_a0(cpu_a0),
    .cpu_ce_n(cpu_ce_n), .cpu_rw(cpu_rw), .cpu_m2(cpu_m2),
    .ppu_addr(ppu_addr), .ext_mode(ext_mode), .mir_h(mir_h),
    .irq_n(irq_n), .ciram_a10(ciram_a10), .prg_ce_n(prg_ce_n),
    .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n),
    .prg_addr(prg_addr), .chr_addr(chr_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] observe(input int kind);
    case (kind)
      K_PRG:   observe = 16'(prg_addr);
      K_CHR:   observe = 16'(chr_addr);
      K_IRQ:   observe = 16'(irq_n);
      K_CIRAM: observe = 16'(ciram_a10);
      K_RAMCE: observe = 16'(ram_ce_n);
      K_RAMWE: observe = 16'(ram_we_n);
      default: observe = 16'(prg_ce_n);
    endcase
  endfunction

  task automatic expect_out(input string tag, input int kind, input int exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = 16'(exp);
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.kind), e.exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m2_cycle();
    cpu_m2 = 1'b1;
    cyc(4);
    cpu_m2 = 1'b0;
    cyc(4);
  endtask

  task automatic cpu_wr(input logic [2:0] r, input logic [7:0] d);
    {cpu_a14, cpu_a13, cpu_a0} = r;
    cpu_data = d;
    cpu_ce_n = 1'b0;
    cpu_rw   = 1'b0;
    m2_cycle();
    cpu_ce_n = 1'b1;
    cpu_rw   = 1'b1;
  endtask

  // Lower A12, let 'falls' M2 falling edges pass, then raise A12
  task automatic a12_rise(input int falls);
    ppu_addr[2] = 1'b0;
    cyc(3);
    repeat (falls) m2_cycle();
    ppu_addr[2] = 1'b1;
    cyc(5);
  endtask

  task automatic probe_prg(input string tag, input logic [1:0] a, input int exp);
    {cpu_a14, cpu_a13} = a;
    expect_out(tag, K_PRG, exp);
    drain();
  endtask

  task automatic probe_chr(input string tag, input logic [2:0] p, input int exp);
    ppu_addr = p;
    expect_out(tag, K_CHR, exp);
    drain();
  endtask

  task automatic do_reset(input logic ext, input logic mir);
    rst_n    = 1'b0;
    ext_mode = ext;
    mir_h    = mir;
    cpu_m2   = 1'b0;
    ppu_addr = 3'b000;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    cpu_data = 8'h00;
    {cpu_a14, cpu_a13, cpu_a0} = 3'b000;
    cpu_ce_n = 1'b1;
    cpu_rw   = 1'b1;
    do_reset(1'b0, 1'b1);

    // Reset state: mirroring from mir_h, default bank registers
    ppu_addr = 3'b010;
    expect_out("rst_irq", K_IRQ, 1);
    expect_out("rst_mir_a11", K_CIRAM, 1);
    expect_out("rst_chr_r1", K_CHR, 2);
    drain();
    ppu_addr = 3'b001;
    expect_out("rst_mir_a10", K_CIRAM, 0);
    expect_out("rst_chr_r0", K_CHR, 1);
    drain();
    probe_chr("rst_chr_r5", 3'b111, 7);
    probe_prg("rst_prg_8000", 2'b00, 0);
    probe_prg("rst_prg_a000", 2'b01, 1);
    probe_prg("rst_prg_c000", 2'b10, 62);
    probe_prg("rst_prg_e000", 2'b11, 63);
    ppu_addr = 3'b000;

    // PRG banking and mode switch
    cpu_wr(3'b000, 8'h06);
    cpu_wr(3'b001, 8'h05);
    probe_prg("prg_r6", 2'b00, 5);
    cpu_wr(3'b000, 8'h46);
    probe_prg("prgm1_8000", 2'b00, 62);
    probe_prg("prgm1_c000", 2'b10, 5);
    probe_prg("prgm1_e000", 2'b11, 63);

    // Bus decode
    cpu_ce_n = 1'b0;
    {cpu_a14, cpu_a13} = 2'b11;
    expect_out("prgce_read", K_PRGCE, 0);
    expect_out("ramce_rom", K_RAMCE, 1);
    drain();
    cpu_ce_n = 1'b1;
    expect_out("prgce_idle", K_PRGCE, 1);
    expect_out("ramce_off", K_RAMCE, 1);
    expect_out("ramwe_read", K_RAMWE, 1);
    drain();
    cpu_rw = 1'b0;
    expect_out("ramwe_write", K_RAMWE, 0);
    drain();
    cpu_rw = 1'b1;
    cpu_wr(3'b011, 8'h80);
    {cpu_a14, cpu_a13} = 2'b11;
    expect_out("ramce_on", K_RAMCE, 0);
    drain();
    {cpu_a14, cpu_a13} = 2'b10;
    expect_out("ramce_wrongaddr", K_RAMCE, 1);
    drain();
    cpu_wr(3'b011, 8'hC0);
    cpu_rw = 1'b0;
    expect_out("ramwe_protect", K_RAMWE, 1);
    drain();
    cpu_rw = 1'b1;
    cpu_wr(3'b010, 8'h00);
    ppu_addr = 3'b001;
    expect_out("mir_v", K_CIRAM, 1);
    drain();

    // CHR invert
    cpu_wr(3'b000, 8'h80);
    probe_chr("inv_lo_r2", 3'b000, 4);
    probe_chr("inv_hi_r0", 3'b101, 1);
    cpu_wr(3'b000, 8'h00);
    ppu_addr = 3'b000;
    cyc(4);

    // Scanline counter with A12 events
    cpu_wr(3'b100, 8'd3);
    cpu_wr(3'b101, 8'd0);
    cpu_wr(3'b111, 8'd0);
    for (int i = 1; i <= 3; i++) begin
      a12_rise(3);
      expect_out($sformatf("a12_rise%0d", i), K_IRQ, 1);
      drain();
    end
    a12_rise(3);
    expect_out("a12_rise4_irq", K_IRQ, 0);
    drain();
    cpu_wr(3'b110, 8'd0);
    expect_out("irq_disable", K_IRQ, 1);
    drain();

    // Short A12 pulses are filtered out; reload stays pending
    cpu_wr(3'b100, 8'd1);
    cpu_wr(3'b101, 8'd0);
    cpu_wr(3'b111, 8'd0);
    repeat (4) a12_rise(1);
    expect_out("filt_short", K_IRQ, 1);
    drain();
    a12_rise(3);
    expect_out("filt_reload", K_IRQ, 1);
    drain();
    a12_rise(3);
    expect_out("filt_irq", K_IRQ, 0);
    drain();
    cpu_wr(3'b110, 8'd0);

    // Latch of zero fires on every event
    cpu_wr(3'b100, 8'd0);
    cpu_wr(3'b101, 8'd0);
    cpu_wr(3'b111, 8'd0);
    a12_rise(3);
    expect_out("latch0_first", K_IRQ, 0);
    drain();
    cpu_wr(3'b110, 8'd0);
    cpu_wr(3'b111, 8'd0);
    a12_rise(3);
    expect_out("latch0_again", K_IRQ, 0);
    drain();
    cpu_wr(3'b110, 8'd0);

    // Extended mode
    do_reset(1'b1, 1'b0);
    cpu_wr(3'b000, 8'h28);
    cpu_wr(3'b001, 8'h33);
    cpu_wr(3'b000, 8'h20);
    probe_chr("ext_chr_r8", 3'b001, 8'h33);
    probe_chr("ext_chr_r0", 3'b000, 0);
    probe_prg("ext_prg_r15", 2'b10, 0);

    cpu_wr(3'b100, 8'd1);
    cpu_wr(3'b101, 8'd1);
    cpu_wr(3'b111, 8'd0);
    repeat (6) m2_cycle();
    expect_out("presc_7falls", K_IRQ, 1);
    drain();
    m2_cycle();
    expect_out("presc_8falls", K_IRQ, 0);
    drain();

    // Asynchronous reset while the IRQ is pending
    rst_n = 1'b0;
    ppu_addr = 3'b100;
    expect_out("arst_irq", K_IRQ, 1);
    expect_out("arst_chr_1000", K_CHR, 4);
    drain();
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
